// File: rtl/sha2_block_pad_if.sv
// Message-word and padded-block handshakes for the SHA-2 block padder.
// The padder consumes fifo_* words and produces shaf_* words.
interface sha2_block_pad_if;
    logic        fifo_rvalid;
    logic [31:0] fifo_rdata;
    logic        fifo_rready;
    logic        shaf_rvalid;
    logic [31:0] shaf_rdata;
    logic        shaf_rready;
    logic        shaf_last;

    modport slave (
        input  fifo_rvalid, fifo_rdata, shaf_rready,
        output fifo_rready, shaf_rvalid, shaf_rdata, shaf_last
    );

    modport master (
        output fifo_rvalid, fifo_rdata, shaf_rready,
        input  fifo_rready, shaf_rvalid, shaf_rdata, shaf_last
    );
endinterface

// File: rtl/sha2_block_pad.sv
// SHA-2 message padder: forwards words, appends 0x80, zero fill and 64-bit length.
// Optional overrun check enabled by SHA2_BLOCK_PAD_LEN_CHECK_EN.
module sha2_block_pad (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     hash_start,
    input  logic                     hash_process,
    input  logic [63:0]              message_length,
    output logic                     pad_done,
    output logic                     len_err,
    sha2_block_pad_if.slave          bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFifo,
        StPad80,
        StPad00,
        StLenHi,
        StLenLo
    } state_t;

    state_t      state;
    logic [63:0] tx_count;
    logic [63:0] msg_len;
    logic        process_flag;

    logic [63:0] rem;
    logic [3:0]  idx;
    logic [3:0]  idx_nxt;
    logic        at_end;
    logic        part;
    logic        drop;
    logic        acc;
    logic        rv;
    logic        fr;
    logic [31:0] rd;
    logic [31:0] part_word;

    assign rem     = msg_len - tx_count;
    assign idx     = tx_count[8:5];
    assign idx_nxt = idx + 4'd1;
    assign at_end  = process_flag && (tx_count == msg_len);
    assign part    = process_flag && bus.fifo_rvalid &&
                     (rem == 64'd8 || rem == 64'd16 || rem == 64'd24);

`ifdef SHA2_BLOCK_PAD_LEN_CHECK_EN
    assign drop = process_flag && bus.fifo_rvalid && (tx_count >= msg_len);
`else
    assign drop = 1'b0;
`endif

    // Keep the top rem bits of the final word and place the 0x80 marker after them.
    always_comb begin
        part_word = bus.fifo_rdata;
        unique case (rem[4:3])
            2'd1:    part_word = {bus.fifo_rdata[31:24], 8'h80, 16'h0};
            2'd2:    part_word = {bus.fifo_rdata[31:16], 8'h80, 8'h0};
            2'd3:    part_word = {bus.fifo_rdata[31:8], 8'h80};
            default: part_word = bus.fifo_rdata;
        endcase
    end

    always_comb begin
        rv = 1'b0;
        fr = 1'b0;
        rd = 32'h0;
        unique case (state)
            StFifo: begin
                if (drop) begin
                    fr = 1'b1;
                end else if (!at_end) begin
                    rv = bus.fifo_rvalid;
                    fr = bus.shaf_rready;
                    rd = part ? part_word : bus.fifo_rdata;
                end
            end
            StPad80: begin
                rv = 1'b1;
                rd = 32'h8000_0000;
            end
            StPad00: rv = 1'b1;
            StLenHi: begin
                rv = 1'b1;
                rd = msg_len[63:32];
            end
            StLenLo: begin
                rv = 1'b1;
                rd = msg_len[31:0];
            end
            default: rv = 1'b0;
        endcase
        if (!rst_ni) begin
            rv = 1'b0;
            fr = 1'b0;
        end
    end

    assign acc             = rv && bus.shaf_rready;
    assign bus.shaf_rvalid = rv;
    assign bus.shaf_rdata  = rd;
    assign bus.fifo_rready = fr;
    assign bus.shaf_last   = rv && (idx == 4'hf);
    assign pad_done        = rst_ni && (state == StLenLo) &&
                             bus.shaf_rready && !hash_start;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= StIdle;
            tx_count     <= 64'd0;
            msg_len      <= 64'd0;
            process_flag <= 1'b0;
        end else begin
            if (hash_process && (state != StIdle || hash_start)) begin
                process_flag <= 1'b1;
                msg_len      <= message_length;
            end else if (hash_start || pad_done) begin
                process_flag <= 1'b0;
            end

            if (hash_start) begin
                tx_count <= 64'd0;
                state    <= StFifo;
            end else begin
                if (acc) tx_count <= tx_count + 64'd32;
                unique case (state)
                    StFifo: begin
                        if (!drop && at_end)
                            state <= StPad80;
                        else if (!drop && part && acc)
                            state <= (idx_nxt == 4'd14) ? StLenHi : StPad00;
                    end
                    StPad80: if (acc)
                        state <= (idx_nxt == 4'd14) ? StLenHi : StPad00;
                    StPad00: if (acc && idx_nxt == 4'd14) state <= StLenHi;
                    StLenHi: if (acc) state <= StLenLo;
                    StLenLo: if (acc) state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef SHA2_BLOCK_PAD_LEN_CHECK_EN
    logic len_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            len_err_q <= 1'b0;
        else if (hash_start)
            len_err_q <= 1'b0;
        else if (state == StFifo && drop)
            len_err_q <= 1'b1;
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha2_block_pad.sv
// Directed-vector bench for sha2_block_pad: known padding results per message.
// Define SHA2_BLOCK_PAD_LEN_CHECK_EN to also exercise the overrun check.
module tb_sha2_block_pad;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        hash_start = 1'b0;
    logic        hash_process = 1'b0;
    logic [63:0] message_length = 64'd0;
    logic        pad_done;
    logic        len_err;

    sha2_block_pad_if bus();

    sha2_block_pad dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .hash_start     (hash_start),
        .hash_process   (hash_process),
        .message_length (message_length),
        .pad_done       (pad_done),
        .len_err        (len_err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    bit          pend_proc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic exp_tail(input int nz, input logic [31:0] lo);
        for (int i = 0; i < nz; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(lo);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        hash_start = 1'b1;
        bus.fifo_rvalid = 1'b0;
        bus.shaf_rready = 1'b1;
        @(negedge clk);
        hash_start = 1'b0;
    endtask

    task automatic pulse_proc(input logic [63:0] len);
        @(negedge clk);
        message_length = len;
        hash_process = 1'b1;
        bus.fifo_rvalid = 1'b0;
        @(negedge clk);
        hash_process = 1'b0;
    endtask

    task automatic drain(input int mode, input string tag);
        int          cyc = 0;
        int          outn = 0;
        int          pads = 0;
        int          nexp = exp_q.size();
        logic        held = 1'b0;
        logic [31:0] hd = 32'h0;
        while (exp_q.size() > 0 && cyc < 300) begin
            @(negedge clk);
            bus.fifo_rvalid = in_q.size() > 0;
            bus.fifo_rdata  = (in_q.size() > 0) ? in_q[0] : 32'h0;
            bus.shaf_rready = (mode == 1) ? cyc[0] : 1'b1;
            hash_process    = pend_proc && in_q.size() == 0;
            if (hash_process) pend_proc = 1'b0;
            #1;
            if (held && bus.shaf_rvalid)
                chk({tag, "_hold"}, {32'h0, bus.shaf_rdata}, {32'h0, hd});
            held = bus.shaf_rvalid && !bus.shaf_rready;
            hd   = bus.shaf_rdata;
            if (pad_done) pads++;
            if (bus.shaf_rvalid && bus.shaf_rready) begin
                chk({tag, "_data"}, {32'h0, bus.shaf_rdata},
                    {32'h0, exp_q.pop_front()});
                chk({tag, "_last"}, {63'h0, bus.shaf_last},
                    {63'h0, outn % 16 == 15});
                outn++;
            end
            if (bus.fifo_rvalid && bus.fifo_rready) void'(in_q.pop_front());
            cyc++;
        end
        @(negedge clk);
        hash_process = 1'b0;
        bus.fifo_rvalid = 1'b0;
        bus.shaf_rready = 1'b1;
        #1;
        chk({tag, "_idle_rv"}, {63'h0, bus.shaf_rvalid}, 64'd0);
        chk({tag, "_idle_pd"}, {63'h0, pad_done}, 64'd0);
        chk({tag, "_pads"}, pads, 64'd1);
        chk({tag, "_count"}, outn, nexp);
        chk({tag, "_fifo"}, in_q.size(), 64'd0);
        exp_q = {};
        in_q = {};
    endtask

    initial begin
        bus.fifo_rvalid = 1'b0;
        bus.fifo_rdata  = 32'h0;
        bus.shaf_rready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rv", {63'h0, bus.shaf_rvalid}, 64'd0);
        chk("rst_fr", {63'h0, bus.fifo_rready}, 64'd0);
        chk("rst_pd", {63'h0, pad_done}, 64'd0);
        chk("rst_last", {63'h0, bus.shaf_last}, 64'd0);
        chk("rst_err", {63'h0, len_err}, 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // empty message
        pulse_start();
        message_length = 64'd0;
        pend_proc = 1'b1;
        exp_q.push_back(32'h8000_0000);
        exp_tail(13, 32'h0);
        drain(0, "empty");

        // "abc"
        pulse_start();
        pulse_proc(64'd24);
        in_q.push_back(32'h6162_6300);
        exp_q.push_back(32'h6162_6380);
        exp_tail(13, 32'h18);
        drain(0, "abc");

        // 448 bits, length given after the data
        pulse_start();
        message_length = 64'd448;
        pend_proc = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_q.push_back(32'h1020_3040 + 32'h0101_0101 * i);
            exp_q.push_back(32'h1020_3040 + 32'h0101_0101 * i);
        end
        exp_q.push_back(32'h8000_0000);
        exp_tail(15, 32'h1C0);
        drain(0, "m448");
        chk("m448_err", {63'h0, len_err}, 64'd0);

        // 512 bits with a toggling consumer
        pulse_start();
        message_length = 64'd512;
        pend_proc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_q.push_back(32'hA5A5_0000 ^ (32'h0001_1111 * i));
            exp_q.push_back(32'hA5A5_0000 ^ (32'h0001_1111 * i));
        end
        exp_q.push_back(32'h8000_0000);
        exp_tail(13, 32'h200);
        drain(1, "m512");

        // restart during zero fill
        pulse_start();
        pulse_proc(64'd8);
        @(negedge clk);
        bus.fifo_rvalid = 1'b1;
        bus.fifo_rdata  = 32'hAABB_CCDD;
        #1;
        chk("rs_part", {32'h0, bus.shaf_rdata}, 64'hAA80_0000);
        @(negedge clk);
        bus.fifo_rvalid = 1'b0;
        #1;
        chk("rs_pad00", {31'h0, bus.shaf_rvalid, bus.shaf_rdata}, 64'h1_0000_0000);
        @(negedge clk);
        hash_start = 1'b1;
        #1;
        chk("rs_nopd", {63'h0, pad_done}, 64'd0);
        @(negedge clk);
        hash_start = 1'b0;
        #1;
        chk("rs_fifo", {63'h0, bus.shaf_rvalid}, 64'd0);
        pulse_proc(64'd16);
        in_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_8000);
        exp_tail(13, 32'h10);
        drain(0, "rs2");

        // reset mid-message
        pulse_start();
        @(negedge clk);
        bus.fifo_rvalid = 1'b1;
        bus.fifo_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("mr_pass", {63'h0, bus.shaf_rvalid}, 64'd1);
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("mr_rv", {63'h0, bus.shaf_rvalid}, 64'd0);
        chk("mr_fr", {63'h0, bus.fifo_rready}, 64'd0);
        chk("mr_pd", {62'h0, pad_done, bus.shaf_last}, 64'd0);
        @(negedge clk);
        bus.fifo_rvalid = 1'b0;

`ifdef SHA2_BLOCK_PAD_LEN_CHECK_EN
        // overrun: second word is dropped
        pulse_start();
        pulse_proc(64'd32);
        in_q.push_back(32'h1111_1111);
        in_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h1111_1111);
        exp_q.push_back(32'h8000_0000);
        exp_tail(12, 32'h20);
        drain(0, "ovr");
        chk("ovr_err", {63'h0, len_err}, 64'd1);
        pulse_start();
        #1;
        chk("ovr_clr", {63'h0, len_err}, 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sha2_block_pad.md
SHA2_BLOCK_PAD -- requirements
Module: sha2_block_pad

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port hash_start, input, 1 bit: one-cycle pulse that begins a new message.
REQ-004 SHALL have port hash_process, input, 1 bit: one-cycle pulse marking end of message input.
REQ-005 SHALL have port message_length, input, 64 bits: message length in bits, a multiple of 8.
REQ-006 SHALL have port fifo_rvalid, input, 1 bit: the message word on fifo_rdata is valid.
REQ-007 SHALL have port fifo_rdata, input, 32 bits: message word, big-endian byte order.
REQ-008 SHALL have port fifo_rready, output, 1 bit: the message word is accepted this cycle.
REQ-009 SHALL have port shaf_rvalid, output, 1 bit: a padded block word is valid.
REQ-010 SHALL have port shaf_rdata, output, 32 bits: padded block word.
REQ-011 SHALL have port shaf_rready, input, 1 bit: the compression engine accepts the word.
REQ-012 SHALL have port shaf_last, output, 1 bit: the current word is word 15 of a 512-bit block.
REQ-013 SHALL have port pad_done, output, 1 bit: one-cycle pulse when the final length word is accepted.
REQ-014 SHALL have port len_err, output, 1 bit: sticky overrun error (see Configuration).

Function
REQ-015 SHALL keep a 64-bit bit counter tx_count.
- Adds 32 on each accepted output word (shaf_rvalid && shaf_rready).
- Word index = tx_count[8:5].
- shaf_last = shaf_rvalid && (index == 15).
REQ-016 SHALL keep process_flag.
- Set by hash_process.
- Cleared by hash_start or pad_done.
- hash_process wins when it coincides with hash_start.
REQ-017 SHALL register message_length into msg_len on hash_process; no other input is sampled for length.
REQ-018 SHALL implement states StIdle, StFifo, StPad80, StPad00, StLenHi, StLenLo.
REQ-019 SHALL, in StIdle, on hash_start clear tx_count and go to StFifo; all other inputs are ignored.
REQ-020 SHALL, in StFifo, pass words through combinationally.
- shaf_rvalid = fifo_rvalid; shaf_rdata = fifo_rdata; fifo_rready = shaf_rready.
- Zero-cycle latency.
REQ-021 SHALL, in StFifo, handle a partial final word when process_flag=1, fifo_rvalid=1 and rem = msg_len - tx_count is 8, 16 or 24.
- Output keeps the top rem bits of fifo_rdata, then byte 0x80, then zeros.
- On acceptance go to StPad00, or StLenHi if the resulting index == 14.
REQ-022 SHALL, in StFifo with process_flag=1 and tx_count == msg_len, go to StPad80 without accepting fifo data.
REQ-023 SHALL, in StPad80, drive shaf_rvalid=1 and shaf_rdata=0x80000000.
- On acceptance go to StLenHi if the resulting index == 14, else StPad00.
REQ-024 SHALL, in StPad00, drive zero words until the index reaches 14, then go to StLenHi.
- Index 15 wraps through 0..13, which adds a block.
REQ-025 SHALL drive msg_len[63:32] in StLenHi, then msg_len[31:0] in StLenLo.
- Acceptance in StLenLo pulses pad_done and returns to StIdle.
REQ-026 SHALL drive fifo_rready=0 in every state except StFifo.
REQ-027 SHALL hold shaf_rdata stable while shaf_rvalid && !shaf_rready in every padding state.
REQ-028 SHALL, on hash_start in any non-idle state, abandon the message, clear tx_count, and enter StFifo the next cycle.

Reset
REQ-029 SHALL, on rst_ni=0 at a clock edge, set state=StIdle, tx_count=0, msg_len=0, process_flag=0, len_err=0.
REQ-030 SHALL drive shaf_rvalid=0, fifo_rready=0, pad_done=0 and shaf_last=0 while in reset and in StIdle; reset mid-message discards all progress.

Configuration
REQ-031 SHALL support the macro SHA2_BLOCK_PAD_LEN_CHECK_EN.
- Defined: len_err sets when a word is accepted in StFifo with process_flag=1 and tx_count >= msg_len. The word is dropped (fifo_rready=1, shaf_rvalid=0). len_err clears on hash_start.
- Undefined: len_err is tied 0 and there is no check logic.

Verification
REQ-032 SHALL pass the empty-message case: hash_start, then hash_process, length 0 -> 0x80000000, 13 zeros, 0x0, 0x0; shaf_last on word 16; one pad_done.
REQ-033 SHALL pass the "abc" case: length 24, one word 0x61626300 -> 0x61626380, 13 zeros, 0x0, 0x00000018.
REQ-034 SHALL pass the 448-bit case: 14 words, length 448 -> 0x80000000 at index 14, 15 zeros, then 0x0, 0x000001C0; 32 words total; shaf_last at words 16 and 32.
REQ-035 SHALL pass the 512-bit case: 16 words, with shaf_rready toggling every cycle -> data unchanged, then 0x80000000, 13 zeros, 0x0, 0x00000200; shaf_rdata stable during stalls.
REQ-036 SHALL pass the restart case: hash_start during StPad00 -> no pad_done; the next message pads correctly; reset asserted mid-StFifo -> all outputs 0 next cycle.
REQ-037 SHALL pass the overrun case with SHA2_BLOCK_PAD_LEN_CHECK_EN: length 32 and two words supplied -> len_err=1, second word not forwarded.
